sawtooth_iter_ctrl: RTL and testbench

Initiator/sequencer for the pipelined sawtooth map unit. It loads a seed and epsilon, issues one map request at a time, and feeds each result back as the next x. The first N_WARMUP results are discarded; after that, each result is converted to a keystream byte for the pixel-XOR stage. It owns iteration counting, warm-up discard, output backpressure and start/done handshaking.

---
 rtl/sawtooth_iter_ctrl_pkg.sv | 18 +
 rtl/sawtooth_iter_ctrl_key_extract.sv | 18 +
 rtl/sawtooth_iter_ctrl.sv | 157 +++++++++++++++
 tb/tb_sawtooth_iter_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sawtooth_iter_ctrl_pkg.sv
// Shared types and constants for the sawtooth map iteration controller.
package sawtooth_iter_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } state_t;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  // The key byte folds the top mantissa byte onto the lowest byte of the word.
  localparam int KEY_HI_LSB = 15;
  localparam int KEY_LO_LSB = 0;

endpackage

// File: rtl/sawtooth_iter_ctrl_key_extract.sv
// Combinational float-to-byte fold producing one keystream byte per map result.
module sawtooth_iter_ctrl_key_extract
  import sawtooth_iter_ctrl_pkg::*;
#(
  parameter int PRECISION = 32
) (
  input  logic [PRECISION-1:0] i_word,
  output logic [7:0]           o_byte
);

  logic w_unused_bits;

  assign o_byte = i_word[KEY_HI_LSB +: 8] ^ i_word[KEY_LO_LSB +: 8];

  // Bits outside the two folded bytes do not contribute to this fold.
  assign w_unused_bits = ^{i_word[PRECISION-1:KEY_HI_LSB+8], i_word[KEY_HI_LSB-1:KEY_LO_LSB+8]};

endmodule

// File: rtl/sawtooth_iter_ctrl.sv
// Sequencer for the sawtooth map unit: seeds, iterates, discards warm-up and emits key bytes.
// Optional response watchdog enabled by defining SAWTOOTH_ITER_WDOG_EN.
module sawtooth_iter_ctrl
  import sawtooth_iter_ctrl_pkg::*;
#(
  parameter int PRECISION   = 32,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PRECISION-1:0] seed_x,
  input  logic [PRECISION-1:0] epsilon,
  input  logic [CNT_W-1:0]     n_warmup,
  input  logic [CNT_W-1:0]     n_out,
  output logic                 saw_tvalid,
  output logic [PRECISION-1:0] saw_x,
  output logic [PRECISION-1:0] saw_epsilon,
  input  logic                 saw_valid,
  input  logic [PRECISION-1:0] saw_result,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [7:0]           key_byte,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t               r_state;
  state_t               w_next;
  logic [PRECISION-1:0] r_x;
  logic [PRECISION-1:0] r_eps;
  logic [PRECISION-1:0] r_saw_x;
  logic [CNT_W-1:0]     r_warm_cnt;
  logic [CNT_W-1:0]     r_out_cnt;
  logic [CNT_W-1:0]     r_n_warmup;
  logic [CNT_W-1:0]     r_n_out;
  logic [7:0]           r_key_byte;
  logic [7:0]           w_key;
  logic                 w_start_ok;
  logic                 w_warm_more;
  logic                 w_last;
  logic                 w_timeout;

  sawtooth_iter_ctrl_key_extract #(.PRECISION(PRECISION)) u_key_extract (
    .i_word (saw_result),
    .o_byte (w_key)
  );

  assign w_start_ok  = start && (n_out != '0);
  assign w_warm_more = r_warm_cnt < r_n_warmup;
  assign w_last      = (r_out_cnt + CNT_W'(1)) == r_n_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (saw_valid)      w_next = w_warm_more ? ST_ISSUE : ST_EMIT;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_EMIT:  if (key_ready) w_next = w_last ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    saw_tvalid = 1'b0;
    key_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      ST_ISSUE: begin saw_tvalid = 1'b1; busy = 1'b1; end
      ST_WAIT:  busy = 1'b1;
      ST_EMIT:  begin key_valid = 1'b1; busy = 1'b1; end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // The issued operand lives in r_saw_x so it holds steady while x is updated mid-WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x        <= '0;
      r_eps      <= '0;
      r_saw_x    <= '0;
      r_warm_cnt <= '0;
      r_out_cnt  <= '0;
      r_n_warmup <= '0;
      r_n_out    <= '0;
      r_key_byte <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start_ok) begin
          r_x        <= seed_x;
          r_saw_x    <= seed_x;
          r_eps      <= epsilon;
          r_warm_cnt <= '0;
          r_out_cnt  <= '0;
          r_n_warmup <= n_warmup;
          r_n_out    <= n_out;
        end
        ST_WAIT: if (saw_valid) begin
          r_x <= saw_result;
          if (w_warm_more) begin
            r_warm_cnt <= r_warm_cnt + CNT_W'(1);
            r_saw_x    <= saw_result;
          end else begin
            r_key_byte <= w_key;
          end
        end
        ST_EMIT: if (key_ready) begin
          r_out_cnt <= r_out_cnt + CNT_W'(1);
          r_saw_x   <= r_x;
        end
        default: ;
      endcase
    end
  end

  assign saw_x       = r_saw_x;
  assign saw_epsilon = r_eps;
  assign key_byte    = r_key_byte;

`ifdef SAWTOOTH_ITER_WDOG_EN
  logic [CNT_W-1:0] r_wdog;
  logic             r_err;

  assign w_timeout = (r_state == ST_WAIT) && !saw_valid && (r_wdog == CNT_W'(WDOG_CYCLES - 1));

  // Counter is held at zero outside WAIT so every entry to WAIT starts a fresh window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_WAIT && !saw_valid) r_wdog <= r_wdog + CNT_W'(1);
      else                                  r_wdog <= '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sawtooth_iter_ctrl.sv
// Directed self-checking bench for sawtooth_iter_ctrl with a behavioural map-unit model.
module tb_sawtooth_iter_ctrl;
  import sawtooth_iter_ctrl_pkg::*;

  localparam int PREC = 32;
  localparam int CW   = 16;
  localparam logic [31:0] SEED_A = 32'h3E99_999A;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [PREC-1:0] seed_x;
  logic [PREC-1:0] epsilon;
  logic [CW-1:0]   n_warmup;
  logic [CW-1:0]   n_out;
  logic            saw_tvalid;
  logic [PREC-1:0] saw_x;
  logic [PREC-1:0] saw_epsilon;
  logic            saw_valid = 1'b0;
  logic [PREC-1:0] saw_result = '0;
  logic            key_valid;
  logic            key_ready;
  logic [7:0]      key_byte;
  logic            busy;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;

  // Model mode: 0 never responds, 1 returns x unchanged, 2 returns x+1.
  int modelMode    = 1;
  int modelLatency = 40;

  int tvalidCnt = 0;
  int doneCnt   = 0;
  int beatCnt   = 0;
  int firedCnt  = 0;
  int kvSeenCnt = 0;
  logic [31:0] xLog[64];
  logic [7:0]  keyLog[64];
  bit          pending = 1'b0;
  int          lat = 0;
  logic [31:0] capX = '0;

  sawtooth_iter_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .seed_x      (seed_x),
    .epsilon     (epsilon),
    .n_warmup    (n_warmup),
    .n_out       (n_out),
    .saw_tvalid  (saw_tvalid),
    .saw_x       (saw_x),
    .saw_epsilon (saw_epsilon),
    .saw_valid   (saw_valid),
    .saw_result  (saw_result),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_byte    (key_byte),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Map model and monitor share the falling edge so they never race the DUT.
  always @(negedge clk) begin
    saw_valid = 1'b0;
    if (pending) begin
      if (lat <= 1) begin
        saw_valid  = 1'b1;
        saw_result = (modelMode == 2) ? capX + 32'd1 : capX;
        pending    = 1'b0;
        firedCnt++;
      end else begin
        lat--;
      end
    end
    if (saw_tvalid) begin
      xLog[tvalidCnt % 64] = saw_x;
      tvalidCnt++;
      if (modelMode != 0) begin
        pending = 1'b1;
        lat     = modelLatency;
        capX    = saw_x;
      end
    end
    if (key_valid) kvSeenCnt++;
    if (key_valid && key_ready) begin
      keyLog[beatCnt % 64] = key_byte;
      beatCnt++;
    end
    if (done) doneCnt++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] e,
                               input logic [15:0] nw, input logic [15:0] no);
    seed_x   = s;
    epsilon  = e;
    n_warmup = nw;
    n_out    = no;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic runUntilDone(input string tag, input int budget);
    int base = doneCnt;
    int n = 0;
    while (doneCnt == base && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, doneCnt - base, 1);
    tick();
  endtask

  task automatic waitTvalid(input string tag, input int target, input int budget);
    int n = 0;
    while (tvalidCnt < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(tvalidCnt >= target), 1);
  endtask

  initial begin
    int tb;
    int bb;
    int db;
    int fb;
    int kb;
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    seed_x   = '0;
    epsilon  = '0;
    n_warmup = '0;
    n_out    = '0;
    key_ready = 1'b1;
    tick(3);
    checkOutput("rst_tvalid", 32'(saw_tvalid), 0);
    checkOutput("rst_saw_x", saw_x, 0);
    checkOutput("rst_saw_eps", saw_epsilon, 0);
    checkOutput("rst_key_valid", 32'(key_valid), 0);
    checkOutput("rst_key_byte", 32'(key_byte), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
    reset = 1'b0;
    tick(2);

    // Fixed-point run: eps=1 keeps x at the seed, so every issue carries the seed.
    tb = tvalidCnt; bb = beatCnt; db = doneCnt;
    applyStimulus(SEED_A, FP_ONE, 16'd2, 16'd3);
    checkOutput("r1_busy_after_start", 32'(busy), 1);
    checkOutput("r1_first_issue", 32'(saw_tvalid), 1);
    checkOutput("r1_first_saw_x", saw_x, SEED_A);
    checkOutput("r1_first_saw_eps", saw_epsilon, FP_ONE);
    runUntilDone("r1_done", 2000);
    checkOutput("r1_issue_count", tvalidCnt - tb, 5);
    for (int i = 0; i < 5; i++) checkOutput("r1_issue_x", xLog[(tb + i) % 64], SEED_A);
    checkOutput("r1_beat_count", beatCnt - bb, 3);
    for (int i = 0; i < 3; i++) checkOutput("r1_key", 32'(keyLog[(bb + i) % 64]), 32'hA9);
    tick(3);
    checkOutput("r1_single_done", doneCnt - db, 1);
    checkOutput("r1_busy_low", 32'(busy), 0);

    // Backpressure on the first key beat.
    key_ready = 1'b0;
    tb = tvalidCnt; bb = beatCnt;
    applyStimulus(SEED_A, FP_ONE, 16'd2, 16'd3);
    n = 0;
    while (!key_valid && n < 1000) begin tick(); n++; end
    checkOutput("r2_key_valid_seen", 32'(key_valid), 1);
    checkOutput("r2_issues_before_stall", tvalidCnt - tb, 3);
    for (int i = 0; i < 10; i++) begin
      checkOutput("r2_stall_byte", 32'(key_byte), 32'hA9);
      checkOutput("r2_stall_valid", 32'(key_valid), 1);
      tick();
    end
    checkOutput("r2_no_issue_in_stall", tvalidCnt - tb, 3);
    key_ready = 1'b1;
    tick();
    checkOutput("r2_issue_after_xfer", 32'(saw_tvalid), 1);
    checkOutput("r2_valid_dropped", 32'(key_valid), 0);
    runUntilDone("r2_done", 2000);
    checkOutput("r2_issue_count", tvalidCnt - tb, 5);
    checkOutput("r2_beat_count", beatCnt - bb, 3);

    // n_out == 0 start is a no-op.
    tb = tvalidCnt; db = doneCnt;
    applyStimulus(SEED_A, FP_ONE, 16'd2, 16'd0);
    checkOutput("n0_busy", 32'(busy), 0);
    tick(10);
    checkOutput("n0_no_issue", tvalidCnt - tb, 0);
    checkOutput("n0_no_done", doneCnt - db, 0);
    checkOutput("n0_busy_later", 32'(busy), 0);

    // Reset during the second WAIT, then let the stale result arrive.
    tb = tvalidCnt;
    applyStimulus(SEED_A, FP_ONE, 16'd2, 16'd3);
    waitTvalid("mr_second_issue", tb + 2, 500);
    tick(5);
    reset = 1'b1;
    #1;
    checkOutput("mr_busy_async", 32'(busy), 0);
    checkOutput("mr_saw_x_async", saw_x, 0);
    tick(2);
    reset = 1'b0;
    tb = tvalidCnt; db = doneCnt; fb = firedCnt; kb = kvSeenCnt;
    tick(60);
    checkOutput("mr_stale_arrived", firedCnt - fb, 1);
    checkOutput("mr_no_issue", tvalidCnt - tb, 0);
    checkOutput("mr_no_key_valid", kvSeenCnt - kb, 0);
    checkOutput("mr_no_done", doneCnt - db, 0);
    checkOutput("mr_busy", 32'(busy), 0);
    checkOutput("mr_key_byte", 32'(key_byte), 0);
    checkOutput("mr_saw_x", saw_x, 0);
    checkOutput("mr_saw_eps", saw_epsilon, 0);

    // start during WAIT with new config is ignored; n_warmup=0 emits the first result.
    tb = tvalidCnt; bb = beatCnt;
    applyStimulus(SEED_A, FP_ONE, 16'd0, 16'd2);
    waitTvalid("ig_first_issue", tb + 1, 500);
    tick(3);
    applyStimulus(32'h4000_0000, 32'h0, 16'd4, 16'd5);
    checkOutput("ig_no_issue", 32'(saw_tvalid), 0);
    checkOutput("ig_busy", 32'(busy), 1);
    checkOutput("ig_saw_x", saw_x, SEED_A);
    checkOutput("ig_saw_eps", saw_epsilon, FP_ONE);
    runUntilDone("ig_done", 2000);
    checkOutput("ig_issue_count", tvalidCnt - tb, 2);
    checkOutput("ig_second_x", xLog[(tb + 1) % 64], SEED_A);
    checkOutput("ig_beat_count", beatCnt - bb, 2);
    checkOutput("ig_key0", 32'(keyLog[bb % 64]), 32'hA9);
    checkOutput("ig_key1", 32'(keyLog[(bb + 1) % 64]), 32'hA9);

    // Feedback run: the model adds 1 so each issue must carry the previous result.
    modelMode = 2;
    modelLatency = 3;
    tb = tvalidCnt; bb = beatCnt;
    applyStimulus(SEED_A, 32'h3F00_0000, 16'd1, 16'd2);
    checkOutput("fb_eps", saw_epsilon, 32'h3F00_0000);
    runUntilDone("fb_done", 500);
    checkOutput("fb_issue_count", tvalidCnt - tb, 3);
    checkOutput("fb_x0", xLog[tb % 64], 32'h3E99_999A);
    checkOutput("fb_x1", xLog[(tb + 1) % 64], 32'h3E99_999B);
    checkOutput("fb_x2", xLog[(tb + 2) % 64], 32'h3E99_999C);
    checkOutput("fb_beat_count", beatCnt - bb, 2);
    checkOutput("fb_key0", 32'(keyLog[bb % 64]), 32'hAF);
    checkOutput("fb_key1", 32'(keyLog[(bb + 1) % 64]), 32'hAE);
    modelMode = 1;
    modelLatency = 40;

`ifdef SAWTOOTH_ITER_WDOG_EN
    modelMode = 0;
    db = doneCnt;
    applyStimulus(SEED_A, FP_ONE, 16'd0, 16'd1);
    checkOutput("wd_issue", 32'(saw_tvalid), 1);
    tick(64);
    checkOutput("wd_no_done_early", 32'(done), 0);
    checkOutput("wd_no_err_early", 32'(err), 0);
    tick();
    checkOutput("wd_done", 32'(done), 1);
    checkOutput("wd_err", 32'(err), 1);
    tick();
    checkOutput("wd_busy_low", 32'(busy), 0);
    modelMode = 1;
    applyStimulus(SEED_A, FP_ONE, 16'd0, 16'd1);
    runUntilDone("wd_rerun_done", 500);
    checkOutput("wd_err_sticky", 32'(err), 1);
`else
    checkOutput("no_wdog_err", 32'(err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
